bcd_step_counter: RTL and testbench

//   Generates the 4-bit BCD digit (0..9) that feeds the seven-segment decoder stage.
//   The digit advances on a prescaled timebase tick (free-run mode) or on a debounced pushbutton press (step mode).

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_step_counter_btn_debounce.sv | 67 ++++++
 rtl/bcd_step_counter.sv | 95 +++++++++
 tb/tb_bcd_step_counter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD step counter and its button debouncer.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {IDLE, PRESS_W, PRESSED, HELD, REL_W} deb_state_t;

  // Bits needed to hold 0..v-1; never less than 1 so degenerate params still elaborate.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_step_counter_btn_debounce.sv
// Pushbutton synchronizer plus debounce FSM; emits one btn_pulse per accepted press.
module btn_debounce
  import bcd_pkg::*;
#(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_pulse
);

  localparam int            CW       = clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          btn_s;
  deb_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  always_comb sync_d = {sync_q[0], btn};
  assign btn_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  // cnt_q counts down the stable samples still required in PRESS_W / REL_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: if (btn_s) begin
          state_q <= PRESS_W;
          cnt_q   <= CNT_LOAD;
        end
        PRESS_W: begin
          if (!btn_s)            state_q <= IDLE;
          else if (cnt_q == '0) begin
            state_q <= PRESSED;
            pulse_q <= 1'b1;
          end else               cnt_q   <= cnt_q - 1'b1;
        end
        PRESSED: state_q <= HELD;
        HELD: if (!btn_s) begin
          state_q <= REL_W;
          cnt_q   <= CNT_LOAD;
        end
        REL_W: begin
          if (btn_s)             state_q <= HELD;
          else if (cnt_q == '0)  state_q <= IDLE;
          else                   cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/bcd_step_counter.sv
// Single BCD digit counter stepped by a prescaled tick or a debounced button.
// Define CNTR_UPDOWN_EN to add the dir port and down counting with borrow.
module bcd_step_counter
  import bcd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       btn,
  input  logic       clr,
`ifdef CNTR_UPDOWN_EN
  input  logic       dir,
`endif
  output logic [3:0] cntr,
  output logic       carry,
  output logic       tick_o
);

  localparam int            DIV  = CLK_HZ / TICK_HZ;
  localparam int            PW   = clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    cntr_q, cntr_d;
  logic          carry_q, carry_d;
  logic          btn_pulse, tick, step, down;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .btn_pulse (btn_pulse)
  );

`ifdef CNTR_UPDOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  assign tick = en && (presc_q == PMAX);
  assign step = en && (mode ? btn_pulse : tick);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (!en || clr || tick) presc_d = '0;
  end

  // Out-of-range values recover to 0 without a carry so a corrupted digit never cascades.
  always_comb begin
    cntr_d  = cntr_q;
    carry_d = 1'b0;
    if (clr) begin
      cntr_d = 4'd0;
    end else if (step) begin
      if (cntr_q > BCD_MAX) begin
        cntr_d = 4'd0;
      end else if (down) begin
        if (cntr_q == 4'd0) begin
          cntr_d  = BCD_MAX;
          carry_d = 1'b1;
        end else begin
          cntr_d = cntr_q - 4'd1;
        end
      end else if (cntr_q == BCD_MAX) begin
        cntr_d  = 4'd0;
        carry_d = 1'b1;
      end else begin
        cntr_d = cntr_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cntr_q  <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cntr_q  <= cntr_d;
      carry_q <= carry_d;
    end
  end

  assign cntr   = cntr_q;
  assign carry  = carry_q;
  assign tick_o = tick;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench for bcd_step_counter with DIV=10 and DEB_CYCLES=4.
module tb_bcd_step_counter;

  localparam int CLK_HZ     = 10;
  localparam int TICK_HZ    = 1;
  localparam int DEB_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, btn, clr, dir;
  logic [3:0] cntr;
  logic       carry, tick_o;

  int checks   = 0;
  int failures = 0;

  bcd_step_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .btn    (btn),
    .clr    (clr),
`ifdef CNTR_UPDOWN_EN
    .dir    (dir),
`endif
    .cntr   (cntr),
    .carry  (carry),
    .tick_o (tick_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  en;
    int    adv;
    int    exp_cntr;
    logic  exp_carry;
    logic  exp_tick;
    string nm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input int c, input int cy, input int tk);
    chk({nm, ".cntr"},  int'(cntr),   c);
    chk({nm, ".carry"}, int'(carry),  cy);
    chk({nm, ".tick"},  int'(tick_o), tk);
  endtask

  initial begin
    // k = posedges since free-run start; cntr = k/10 mod 10, tick when k%10==9
    vecs[0] = '{1'b1,  9, 0, 1'b0, 1'b1, "fr_k9"};
    vecs[1] = '{1'b1,  1, 1, 1'b0, 1'b0, "fr_k10"};
    vecs[2] = '{1'b1,  9, 1, 1'b0, 1'b1, "fr_k19"};
    vecs[3] = '{1'b1, 31, 5, 1'b0, 1'b0, "fr_k50"};
    vecs[4] = '{1'b1, 49, 9, 1'b0, 1'b1, "fr_k99"};
    vecs[5] = '{1'b1,  1, 0, 1'b1, 1'b0, "fr_wrap"};
    vecs[6] = '{1'b1,  1, 0, 1'b0, 1'b0, "fr_after_wrap"};
    vecs[7] = '{1'b1, 33, 3, 1'b0, 1'b0, "fr_k134"};
    vecs[8] = '{1'b0, 25, 3, 1'b0, 1'b0, "en_off_frozen"};
    vecs[9] = '{1'b1,  9, 3, 1'b0, 1'b1, "en_on_first_tick"};

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; btn = 1'b0; clr = 1'b0; dir = 1'b0;
    cyc(2);
    chk_out("reset", 0, 0, 0);

    rst_n = 1'b1; en = 1'b1;
    foreach (vecs[i]) begin
      en = vecs[i].en;
      cyc(vecs[i].adv);
      chk_out(vecs[i].nm, vecs[i].exp_cntr, int'(vecs[i].exp_carry), int'(vecs[i].exp_tick));
    end
    cyc(1);
    chk("en_on_step.cntr", int'(cntr), 4);

    // Asynchronous reset in the middle of a count
    cyc(10);
    chk("pre_reset.cntr", int'(cntr), 5);
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8);
    chk("post_reset_no_tick", int'(tick_o), 0);
    cyc(1);
    chk("post_reset_tick", int'(tick_o), 1);
    cyc(1);
    chk("post_reset_step.cntr", int'(cntr), 1);

    // clr wins over a tick at cntr=9
    cyc(80);
    chk("pre_clr.cntr", int'(cntr), 9);
    cyc(9);
    chk_out("clr_setup", 9, 0, 1);
    clr = 1'b1;
    cyc(1);
    chk("clr_tick.cntr", int'(cntr), 0);
    chk("clr_tick.carry", int'(carry), 0);
    clr = 1'b0;
    cyc(1);
    chk("after_clr.carry", int'(carry), 0);

    // Step mode: glitches ignored, one increment per held press
    mode = 1'b1;
    btn = 1'b1; cyc(1); btn = 1'b0; cyc(1);
    btn = 1'b1; cyc(1); btn = 1'b0; cyc(6);
    chk("glitch_no_step", int'(cntr), 0);
    btn = 1'b1;
    cyc(7);
    chk("press_latency_minus1", int'(cntr), 0);
    cyc(1);
    chk("press_step", int'(cntr), 1);
    chk("press_carry", int'(carry), 0);
    cyc(12);
    chk("held_no_repeat", int'(cntr), 1);
    btn = 1'b0;
    cyc(20);
    chk("release_no_step", int'(cntr), 1);
    btn = 1'b1; cyc(3); btn = 1'b0;
    cyc(20);
    chk("short_pulse_no_step", int'(cntr), 1);
    btn = 1'b1;
    cyc(8);
    chk("second_press_step", int'(cntr), 2);
    btn = 1'b0;
    cyc(20);

`ifdef CNTR_UPDOWN_EN
    // Down count borrow from 0 to 9
    clr = 1'b1; cyc(1); clr = 1'b0;
    mode = 1'b0; dir = 1'b1;
    cyc(9);
    chk("down_setup.tick", int'(tick_o), 1);
    cyc(1);
    chk("down_borrow.cntr", int'(cntr), 9);
    chk("down_borrow.carry", int'(carry), 1);
    cyc(10);
    chk("down_step.cntr", int'(cntr), 8);
    chk("down_step.carry", int'(carry), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
